// File: rtl/crypto_itf_ctrl.sv
// Host-to-cryptocore interface: input word bank, start/busy/done handshake with optional watchdog,
// done-time capture of core results into shadow registers. Optional input readback: ITF_READBACK_EN.
module crypto_itf_ctrl #(
  parameter int WIDTH       = 64,
  parameter int ADDR_W      = 8,
  parameter int IN_REG      = 34,
  parameter int OUT_REG     = 9,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                control,
  input  logic [ADDR_W-1:0]         address,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      end_op,
  output logic [IN_REG*WIDTH-1:0]   core_din,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [OUT_REG*WIDTH-1:0]  core_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam int WD_W  = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_EN ? WD_W'(TIMEOUT_CYC)     : '0;
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;

  logic rd_en, ld_en, st_en, clr;
  assign rd_en = control[3];
  assign ld_en = control[2];
  assign st_en = control[1];
  assign clr   = rst | control[0];

  state_e                    state_q;
  logic [WD_W-1:0]           wd_cnt_q;
  logic                      core_start_q;
  logic                      end_op_q;
  logic                      addr_err_q, lock_err_q, overrun_q, timeout_q;
  logic [IN_REG*WIDTH-1:0]   din_q, din_d;
  logic [OUT_REG*WIDTH-1:0]  shadow_q;
  logic [WIDTH-1:0]          data_out_q, rd_mux, status_w;

  logic locked, addr_ok, wr_ok, capture, wd_fire;

  assign locked  = (state_q == S_START) || (state_q == S_BUSY);
  assign addr_ok = int'(address) < IN_REG;
  assign wr_ok   = ld_en && !locked && addr_ok;
  assign capture = core_done && locked;
  assign wd_fire = WD_EN && (state_q == S_BUSY) && !core_done && (wd_cnt_q == WD_LAST);

  // Handshake FSM; core_start and end_op are registered alongside the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      wd_cnt_q     <= '0;
      core_start_q <= 1'b0;
      end_op_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      lock_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (st_en) begin
            state_q      <= S_START;
            core_start_q <= 1'b1;
            wd_cnt_q     <= '0;
          end
        end
        S_START: begin
          if (core_done) begin
            state_q  <= S_DONE;
            end_op_q <= 1'b1;
          end else begin
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (WD_EN && (wd_cnt_q != WD_MAX)) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (core_done) begin
            state_q  <= S_DONE;
            end_op_q <= 1'b1;
          end else if (wd_fire) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (st_en) begin
            state_q      <= S_START;
            core_start_q <= 1'b1;
            end_op_q     <= 1'b0;
            wd_cnt_q     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Error flags are sticky until a reset of either kind.
      if (st_en && locked)                 overrun_q  <= 1'b1;
      if (ld_en && locked)                 lock_err_q <= 1'b1;
      if (ld_en && !locked && !addr_ok)    addr_err_q <= 1'b1;
    end
  end

  always_comb begin
    din_d = din_q;
    for (int k = 0; k < IN_REG; k++) begin
      if (int'(address) == k) din_d[k*WIDTH +: WIDTH] = data_in;
    end
  end

  always_comb begin
    status_w      = '0;
    status_w[5:0] = {timeout_q, overrun_q, lock_err_q, addr_err_q, locked, end_op_q};
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < OUT_REG; k++) begin
      if (int'(address) == k) rd_mux = shadow_q[k*WIDTH +: WIDTH];
    end
    if (int'(address) == OUT_REG) rd_mux = status_w;
`ifdef ITF_READBACK_EN
    for (int k = 0; k < IN_REG; k++) begin
      if (int'(address) == OUT_REG + 1 + k) rd_mux = din_q[k*WIDTH +: WIDTH];
    end
`endif
  end

  // Flags feeding the status read are the pre-edge values, so a read racing an event sees the old state.
  always_ff @(posedge clk) begin
    if (clr) begin
      din_q      <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_ok)   din_q      <= din_d;
      if (capture) shadow_q   <= core_dout;
      if (rd_en)   data_out_q <= rd_mux;
    end
  end

  assign data_out   = data_out_q;
  assign end_op     = end_op_q;
  assign core_din   = din_q;
  assign core_start = core_start_q;

endmodule

// File: tb/tb_crypto_itf_ctrl.sv
// Bench for crypto_itf_ctrl: read results are scoreboarded (expected pushed at issue, compared one
// cycle later); handshake, watchdog, error flags and bank contents checked directly.
module tb_crypto_itf_ctrl;
  localparam int WIDTH   = 64;
  localparam int ADDR_W  = 8;
  localparam int IN_REG  = 34;
  localparam int OUT_REG = 9;
  localparam int TMO     = 16;
  localparam int ST_ADDR = OUT_REG;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [3:0]               control;
  logic [ADDR_W-1:0]        address;
  logic [WIDTH-1:0]         data_in;
  logic [WIDTH-1:0]         data_out;
  logic                     end_op;
  logic [IN_REG*WIDTH-1:0]  core_din;
  logic                     core_start;
  logic                     core_done;
  logic [OUT_REG*WIDTH-1:0] core_dout;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic [WIDTH-1:0] sb_q[$];

  crypto_itf_ctrl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .IN_REG(IN_REG), .OUT_REG(OUT_REG), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .control(control), .address(address), .data_in(data_in),
    .data_out(data_out), .end_op(end_op), .core_din(core_din), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) start_cnt++;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; a read issued this cycle is checked against the scoreboard after the edge.
  task automatic cycle();
    logic rd_now;
    logic [WIDTH-1:0] e;
    rd_now = control[3];
    @(posedge clk);
    #1;
    if (rd_now) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("read", data_out, e);
      end
    end
    control = 4'b0000;
  endtask

  task automatic do_read(input int a, input logic [WIDTH-1:0] exp);
    address = ADDR_W'(a);
    control = 4'b1000;
    sb_q.push_back(exp);
    cycle();
  endtask

  task automatic do_write(input int a, input logic [WIDTH-1:0] d);
    address = ADDR_W'(a);
    data_in = d;
    control = 4'b0100;
    cycle();
  endtask

  task automatic do_cmd(input logic [3:0] c);
    control = c;
    cycle();
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] din_word(input int k);
    return core_din[k*WIDTH +: WIDTH];
  endfunction

  logic [WIDTH-1:0] rb_exp;

  initial begin
    rst = 1'b1; control = '0; address = '0; data_in = '0; core_done = 1'b0; core_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_data_out", data_out, 0);
    check_val("rst_end_op", {63'd0, end_op}, 0);
    check_val("rst_core_start", {63'd0, core_start}, 0);
    check_val("rst_core_din", {63'd0, core_din == '0}, 1);
    do_read(ST_ADDR, 64'h0);

    // Basic transaction.
    do_write(3, 64'hDEADBEEF);
    check_val("wr_word3", din_word(3), 64'hDEADBEEF);
    core_dout[0 +: WIDTH] = 64'h1234;
    do_cmd(4'b0010);
    check_val("start_pulse_hi", {63'd0, core_start}, 1);
    cycle();
    check_val("start_pulse_lo", {63'd0, core_start}, 0);
    cycle();
    pulse_done();
    check_val("done_end_op", {63'd0, end_op}, 1);
    check_val("one_pulse", 64'(start_cnt), 1);
    do_read(0, 64'h1234);
    do_read(ST_ADDR, 64'h1);
    cycle();
    check_val("read_hold", data_out, 64'h1);

    // Load and start while busy.
    do_cmd(4'b0010);
    cycle();
    do_write(2, 64'h55);
    check_val("locked_word2", din_word(2), 64'h0);
    do_cmd(4'b0010);
    check_val("busy_end_op", {63'd0, end_op}, 0);
    do_read(ST_ADDR, 64'h1A);
    core_dout[0 +: WIDTH]     = 64'h4321;
    core_dout[WIDTH +: WIDTH] = 64'h77;
    pulse_done();
    check_val("done2_end_op", {63'd0, end_op}, 1);
    do_read(ST_ADDR, 64'h19);
    do_read(0, 64'h4321);
    do_read(1, 64'h77);

    // rst_itf clears everything; a late core_done is ignored.
    do_cmd(4'b0001);
    do_read(ST_ADDR, 64'h0);
    do_read(0, 64'h0);
    check_val("itf_core_din", {63'd0, core_din == '0}, 1);
    do_cmd(4'b0010);
    cycle();
    do_cmd(4'b0001);
    pulse_done();
    check_val("late_done_end_op", {63'd0, end_op}, 0);
    do_read(ST_ADDR, 64'h0);
    check_val("pulse_count", 64'(start_cnt), 3);

    // Watchdog: result captured, then a run that never completes.
    do_write(0, 64'h99);
    do_cmd(4'b0010);
    cycle();
    core_dout[0 +: WIDTH] = 64'hABC;
    pulse_done();
    do_read(ST_ADDR, 64'h1);
    core_dout[0 +: WIDTH] = 64'hFFFF;
    do_cmd(4'b0010);
    cycle();
    repeat (TMO - 1) cycle();
    do_read(ST_ADDR, 64'h2);
    do_read(ST_ADDR, 64'h20);
    check_val("tmo_end_op", {63'd0, end_op}, 0);
    do_read(0, 64'hABC);

    // Out-of-range write, then rst_itf.
    do_cmd(4'b0001);
    do_write(2, 64'h11);
    check_val("wr_word2", din_word(2), 64'h11);
    do_write(IN_REG, 64'hBAD);
    check_val("oob_word2", din_word(2), 64'h11);
    check_val("oob_word33", din_word(IN_REG - 1), 64'h0);
    do_read(ST_ADDR, 64'h4);
    do_cmd(4'b0001);
    do_read(ST_ADDR, 64'h0);
    check_val("itf2_core_din", {63'd0, core_din == '0}, 1);

    // Readback region.
    do_write(5, 64'hA5);
`ifdef ITF_READBACK_EN
    rb_exp = 64'hA5;
`else
    rb_exp = 64'h0;
`endif
    do_read(OUT_REG + 6, rb_exp);
    do_read(OUT_REG + 1, 64'h0);
    do_read(200, 64'h0);

    // Load and start together in IDLE.
    address = 8'd7; data_in = 64'h77; control = 4'b0110;
    cycle();
    check_val("ls_word7", din_word(7), 64'h77);
    check_val("ls_start", {63'd0, core_start}, 1);
    pulse_done();
    check_val("ls_end_op", {63'd0, end_op}, 1);
    do_read(ST_ADDR, 64'h1);

    check_val("sb_drain", 64'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
